// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: ALU ops, opcodes, funct3 values,
// FSM states, writeback selects and instruction classes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    AluAdd   = 4'b0000,
    AluSub   = 4'b0001,
    AluSll   = 4'b0010,
    AluSlt   = 4'b0011,
    AluSltu  = 4'b0100,
    AluXor   = 4'b0101,
    AluSrl   = 4'b0110,
    AluSra   = 4'b0111,
    AluOr    = 4'b1000,
    AluAnd   = 4'b1001,
    AluPassB = 4'b1010
  } alu_op_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Sr     = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    WbAlu  = 2'd0,
    WbLoad = 2'd1,
    WbPc4  = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLui,
    ClsAuipc,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJump
  } instr_cls_e;

  // alt selects SUB/SRA; callers decide when funct7[5] is meaningful.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3AddSub: op = alt ? AluSub : AluAdd;
      F3Sll:    op = AluSll;
      F3Slt:    op = AluSlt;
      F3Sltu:   op = AluSltu;
      F3Xor:    op = AluXor;
      F3Sr:     op = alt ? AluSra : AluSrl;
      F3Or:     op = AluOr;
      default:  op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Instruction and data memory handshake bundle between the control unit and the memories.
interface mc_control_unit_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [1:0]  dmem_size;
  logic        dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we, dmem_size,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we, dmem_size,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/rv_decoder.sv
// Combinational RV32I decode of the latched instruction fields into ALU op, operand selects,
// writeback select, instruction class and an illegal-instruction flag.
module rv_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_e    alu_ctrl_o,
  output logic       alu_src_a_o,
  output logic       alu_src_b_o,
  output wb_sel_e    wb_sel_o,
  output instr_cls_e cls_o,
  output logic       illegal_o
);
  logic f7_zero, f7_alt;

  assign f7_zero = (funct7_i == 7'b0000000);
  assign f7_alt  = (funct7_i == 7'b0100000);

  always_comb begin
    alu_ctrl_o  = AluAdd;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    wb_sel_o    = WbAlu;
    cls_o       = ClsAlu;
    illegal_o   = 1'b0;
    case (opcode_i)
      OpReg: begin
        alu_ctrl_o = alu_from_f3(funct3_i, funct7_i[5]);
        illegal_o  = !(f7_zero || (f7_alt && (funct3_i == F3AddSub || funct3_i == F3Sr)));
      end
      OpImm: begin
        alu_src_b_o = 1'b1;
        // funct7 only qualifies shift-immediates; elsewhere those bits are immediate data.
        alu_ctrl_o  = alu_from_f3(funct3_i, (funct3_i == F3Sr) && funct7_i[5]);
        if (funct3_i == F3Sll)     illegal_o = !f7_zero;
        else if (funct3_i == F3Sr) illegal_o = !(f7_zero || f7_alt);
      end
      OpLui: begin
        cls_o       = ClsLui;
        alu_src_b_o = 1'b1;
        alu_ctrl_o  = AluPassB;
      end
      OpAuipc: begin
        cls_o       = ClsAuipc;
        alu_src_a_o = 1'b1;
        alu_src_b_o = 1'b1;
      end
      OpJal: begin
        cls_o       = ClsJump;
        alu_src_a_o = 1'b1;
        alu_src_b_o = 1'b1;
        wb_sel_o    = WbPc4;
      end
      OpJalr: begin
        cls_o       = ClsJump;
        alu_src_b_o = 1'b1;
        wb_sel_o    = WbPc4;
        illegal_o   = (funct3_i != 3'b000);
      end
      OpBranch: begin
        cls_o = ClsBranch;
        case (funct3_i)
          F3Beq, F3Bne:   alu_ctrl_o = AluSub;
          F3Blt, F3Bge:   alu_ctrl_o = AluSlt;
          F3Bltu, F3Bgeu: alu_ctrl_o = AluSltu;
          default:        illegal_o  = 1'b1;
        endcase
      end
      OpLoad: begin
        cls_o       = ClsLoad;
        alu_src_b_o = 1'b1;
        wb_sel_o    = WbLoad;
        illegal_o   = !(funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OpStore: begin
        cls_o       = ClsStore;
        alu_src_b_o = 1'b1;
        illegal_o   = (funct3_i > 3'b010);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns the IR, the memory handshakes,
// the bus timeout and the sticky trap flags; decode is delegated to rv_decoder.
module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_IR       = 32'h0000_0013
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  mc_control_unit_if.master        bus,
  input  logic                     i_branch_taken,
  output logic [31:0]              o_ir,
  output logic [3:0]               o_alu_ctrl,
  output logic                     o_alu_src_a,
  output logic                     o_alu_src_b,
  output logic                     o_reg_we,
  output logic [1:0]               o_wb_sel,
  output logic                     o_pc_we,
  output logic                     o_pc_sel,
  output logic                     o_illegal,
  output logic                     o_bus_err,
  output logic [2:0]               o_state
);
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;

  alu_op_e    dec_alu;
  wb_sel_e    dec_wb_sel;
  instr_cls_e dec_cls;
  logic       dec_illegal;
  logic       timeout;

  rv_decoder u_decoder (
    .opcode_i    (ir_q[6:0]),
    .funct3_i    (ir_q[14:12]),
    .funct7_i    (ir_q[31:25]),
    .alu_ctrl_o  (dec_alu),
    .alu_src_a_o (o_alu_src_a),
    .alu_src_b_o (o_alu_src_b),
    .wb_sel_o    (dec_wb_sel),
    .cls_o       (dec_cls),
    .illegal_o   (dec_illegal)
  );

  // Wait counter sits at the last allowed cycle; an ack in that cycle still wins.
  assign timeout = (TIMEOUT_CYCLES != 0) && (wait_q == WaitLast);

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    wait_d       = '0;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    o_reg_we     = 1'b0;
    o_pc_we      = 1'b0;
    o_pc_sel     = 1'b0;
    case (state_q)
      StFetch: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = StDecode;
        end else if (timeout) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + CntW'(1);
        end
      end
      StDecode: begin
        if (dec_illegal) begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (dec_cls)
          ClsLoad, ClsStore: state_d = StMem;
          ClsBranch: begin
            o_pc_we  = 1'b1;
            o_pc_sel = i_branch_taken;
            state_d  = StFetch;
          end
          ClsJump: begin
            o_reg_we = 1'b1;
            o_pc_we  = 1'b1;
            o_pc_sel = 1'b1;
            state_d  = StFetch;
          end
          default: state_d = StWb;
        endcase
      end
      StMem: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (dec_cls == ClsStore);
        if (bus.dmem_ack) begin
          if (dec_cls == ClsStore) begin
            o_pc_we = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + CntW'(1);
        end
      end
      StWb: begin
        o_reg_we = 1'b1;
        o_pc_we  = 1'b1;
        state_d  = StFetch;
      end
      default: state_d = StTrap;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StFetch;
      ir_q      <= RESET_IR;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.dmem_size = ir_q[13:12];
  assign o_ir          = ir_q;
  assign o_alu_ctrl    = dec_alu;
  assign o_wb_sel      = dec_wb_sel;
  assign o_illegal     = illegal_q;
  assign o_bus_err     = bus_err_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks representative instructions through the FSM
// and checks controls cycle by cycle against hand-derived values.
module tb_mc_control_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        taken = 1'b0;
  logic [31:0] ir;
  logic [3:0]  alu_ctrl;
  logic        src_a, src_b, reg_we, pc_we, pc_sel, illegal, bus_err;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  int          n_vec = 0;
  int          n_miss = 0;

  mc_control_unit_if bus ();

  mc_control_unit #(
    .TIMEOUT_CYCLES (16),
    .RESET_IR       (32'h0000_0013)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .bus            (bus),
    .i_branch_taken (taken),
    .o_ir           (ir),
    .o_alu_ctrl     (alu_ctrl),
    .o_alu_src_a    (src_a),
    .o_alu_src_b    (src_b),
    .o_reg_we       (reg_we),
    .o_wb_sel       (wb_sel),
    .o_pc_we        (pc_we),
    .o_pc_sel       (pc_sel),
    .o_illegal      (illegal),
    .o_bus_err      (bus_err),
    .o_state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch; returns one time unit into the DECODE cycle.
  task automatic fetch(input logic [31:0] instr);
    chk("fetch_req", 32'(bus.imem_req), 1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = instr;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    chk("fetch_ir", ir, instr);
    chk("decode_state", 32'(state), 1);
  endtask

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_flags", 32'({illegal, bus_err}), 0);
    chk("rst_en", 32'({reg_we, pc_we, bus.dmem_req}), 0);
    chk("rst_alu", 32'(alu_ctrl), 0);
    rst = 1'b0;
    #1;
    chk("rel_imem_req", 32'(bus.imem_req), 1);

    // addi x5,x0,2047
    fetch(32'h7FF00293);
    chk("addi_alu", 32'(alu_ctrl), 0);
    chk("addi_srcb", 32'(src_b), 1);
    chk("addi_dec_we", 32'(reg_we), 0);
    step();
    chk("addi_exec_state", 32'(state), 2);
    chk("addi_exec_we", 32'({reg_we, pc_we}), 0);
    step();
    chk("addi_wb_we", 32'({reg_we, pc_we, pc_sel}), 3'b110);
    chk("addi_wb_sel", 32'(wb_sel), 0);
    step();
    chk("addi_next_fetch", 32'({state, reg_we, bus.imem_req}), 5'b000_01);

    fetch(32'h41D38E33);
    chk("sub_alu", 32'(alu_ctrl), 4'b0001);
    chk("sub_srcb", 32'(src_b), 0);
    step();
    step();
    chk("sub_wb_we", 32'(reg_we), 1);
    step();

    fetch(32'h4072D2B3);
    chk("sra_alu", 32'(alu_ctrl), 4'b0111);
    step();
    step();
    step();

    fetch(32'h800FF337);
    chk("lui_alu", 32'(alu_ctrl), 4'b1010);
    step();
    step();
    chk("lui_wb_we", 32'(reg_we), 1);
    step();

    // lb with three wait cycles before ack
    fetch(32'h00400383);
    chk("lb_alu", 32'(alu_ctrl), 0);
    step();
    chk("lb_exec_req", 32'(bus.dmem_req), 0);
    step();
    chk("lb_mem_req", 32'({bus.dmem_req, bus.dmem_we}), 2'b10);
    chk("lb_size", 32'(bus.dmem_size), 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("lb_wait_req", 32'({bus.dmem_req, reg_we, pc_we}), 3'b100);
    end
    step();
    bus.dmem_ack = 1'b1;
    #1;
    chk("lb_ack_cycle", 32'({bus.dmem_req, reg_we, pc_we}), 3'b100);
    step();
    bus.dmem_ack = 1'b0;
    chk("lb_wb_state", 32'(state), 4);
    chk("lb_wb_ctl", 32'({bus.dmem_req, reg_we, pc_we, pc_sel}), 4'b0110);
    chk("lb_wb_sel", 32'(wb_sel), 1);
    step();
    chk("lb_next_fetch", 32'(state), 0);

    // sw with zero-wait ack
    fetch(32'h00602023);
    step();
    step();
    bus.dmem_ack = 1'b1;
    #1;
    chk("sw_mem_req", 32'({bus.dmem_req, bus.dmem_we}), 2'b11);
    chk("sw_size", 32'(bus.dmem_size), 2'b10);
    chk("sw_pc", 32'({pc_we, pc_sel, reg_we}), 3'b100);
    step();
    bus.dmem_ack = 1'b0;
    chk("sw_after", 32'({state, bus.dmem_req, reg_we, pc_we}), 6'b000_000);

    // beq taken: three cycles total
    fetch(32'h02628063);
    chk("beq_alu", 32'(alu_ctrl), 4'b0001);
    step();
    taken = 1'b1;
    #1;
    chk("beq_pc", 32'({pc_we, pc_sel, reg_we}), 3'b110);
    step();
    taken = 1'b0;
    chk("beq_next_fetch", 32'(state), 0);

    fetch(32'hFE5FF3EF);
    chk("jal_src", 32'({src_a, src_b}), 2'b11);
    step();
    chk("jal_exec", 32'({reg_we, pc_we, pc_sel}), 3'b111);
    chk("jal_wb_sel", 32'(wb_sel), 2);
    step();
    chk("jal_next", 32'({state, reg_we}), 4'b000_0);

    // Ack on the final allowed wait cycle must not trap.
    repeat (15) step();
    chk("limit_still_fetch", 32'({state, bus_err}), 4'b000_0);
    fetch(32'h7FF00293);
    chk("limit_no_buserr", 32'(bus_err), 0);
    step();
    step();
    step();

    // Reset during a data wait drops the request at once.
    fetch(32'h00400383);
    step();
    step();
    step();
    chk("mid_mem_req", 32'(bus.dmem_req), 1);
    rst = 1'b1;
    #1;
    chk("rst_drop_req", 32'(bus.dmem_req), 0);
    chk("rst_mid_state", 32'(state), 0);
    chk("rst_mid_ir", ir, 32'h0000_0013);
    chk("rst_mid_we", 32'({reg_we, pc_we}), 0);
    step();
    rst = 1'b0;
    #1;

    // Fetch never acked: trap after sixteen cycles.
    repeat (15) step();
    chk("to_pre_state", 32'({state, bus_err}), 4'b000_0);
    step();
    chk("to_state", 32'(state), 7);
    chk("to_flags", 32'({bus_err, illegal}), 2'b10);
    chk("to_no_req", 32'(bus.imem_req), 0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_clear_buserr", 32'(bus_err), 0);
    fetch(32'h00000000);
    chk("ill_dec_flag", 32'(illegal), 0);
    step();
    chk("ill_state", 32'(state), 7);
    chk("ill_flag", 32'(illegal), 1);
    repeat (3) step();
    chk("ill_hold", 32'({state, bus.imem_req, reg_we, pc_we}), 6'b111_000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
